// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU controller: instruction fields,
// FSM states, ALU operation codes, datapath select values and the decoded
// instruction-class bundle.
package mcpu_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    // ALU B input selects
    localparam logic [1:0] SRCB_REGB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMMSH   = 2'd3;

    // Register file write-address selects
    localparam logic [1:0] DST_RD       = 2'd0;
    localparam logic [1:0] DST_R31      = 2'd1;
    localparam logic [1:0] DST_RT       = 2'd2;

    // Register file write-data selects
    localparam logic [1:0] WD_ALUOUT    = 2'd0;
    localparam logic [1:0] WD_MDR       = 2'd1;
    localparam logic [1:0] WD_PC        = 2'd2;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    // Instruction class produced by the decoder
    typedef struct packed {
        logic       mem;      // LW or SW
        logic       rimm;     // ADDI or XORI
        logic       rtype;    // ADD, SUB, SLT
        logic       branch;   // BEQ or BNE
        logic       jump;     // J, JAL or JR
        logic       jal;
        logic       jr;
        logic       illegal;
        logic [2:0] alu;
    } dec_t;

endpackage

// File: rtl/mcpu_op_decode.sv
// Combinational instruction-class decode from {opcode, funct}. Anything not
// in the supported set is flagged illegal so the controller can halt.
module mcpu_op_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Classify the instruction and pick the ALU operation it needs
    always_comb begin
        dec     = '0;
        dec.alu = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: dec.rtype = 1'b1;
                    FN_SUB: begin
                        dec.rtype = 1'b1;
                        dec.alu   = ALU_SUB;
                    end
                    FN_SLT: begin
                        dec.rtype = 1'b1;
                        dec.alu   = ALU_SLT;
                    end
                    FN_JR: begin
                        dec.jump = 1'b1;
                        dec.jr   = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LW, OP_SW: dec.mem = 1'b1;
            OP_ADDI:      dec.rimm = 1'b1;
            OP_XORI: begin
                dec.rimm = 1'b1;
                dec.alu  = ALU_XOR;
            end
            OP_BEQ, OP_BNE: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
            end
            OP_J:   dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump = 1'b1;
                dec.jal  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: sequences the shared datapath through
// fetch/decode/execute/memory/write-back. Outputs are decoded from the
// current state and the instruction captured at DECODE, and are all forced
// low while reset is held.
module multicycle_control
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUcntrl,
    output logic       instr_done,
    output logic       halted
);

    state_t      state;
    logic [11:0] op_q;
    logic [11:0] dec_in;
    dec_t        dec;
    logic        is_sw;
    logic        is_beq;

    // In DECODE the live IR picks the next state; afterwards only the
    // captured copy is used, so IR changes later in the instruction are ignored
    assign dec_in = (state == ST_DECODE) ? {opcode, funct} : op_q;
    assign is_sw  = (op_q[11:6] == OP_SW);
    assign is_beq = (op_q[11:6] == OP_BEQ);

    mcpu_op_decode u_decode (
        .opcode (dec_in[11:6]),
        .funct  (dec_in[5:0]),
        .dec    (dec)
    );

    // State sequencing and capture of the instruction fields at DECODE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            op_q  <= '0;
        end else begin
            case (state)
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    op_q <= {opcode, funct};
                    if (dec.illegal)
                        state <= ST_HALT;
                    else if (dec.branch)
                        state <= ST_BRANCH;
                    else if (dec.jump)
                        state <= ST_JUMP;
                    else
                        state <= ST_EXEC;
                end
                ST_EXEC:   state <= dec.mem ? ST_MEM : ST_WB;
                ST_MEM:    state <= is_sw ? ST_FETCH : ST_WB;
                ST_WB:     state <= ST_FETCH;
                ST_BRANCH: state <= ST_FETCH;
                ST_JUMP:   state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; everything defaults to zero/disabled
    always_comb begin
        PCWr       = 1'b0;
        PCSrc      = PCSRC_ALU;
        IorD       = 1'b0;
        MemWr      = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        RegDst     = DST_RD;
        MemToReg   = WD_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        ALUcntrl   = ALU_ADD;
        instr_done = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    IRWr    = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    PCWr    = 1'b1;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                end
                ST_EXEC: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = dec.rtype ? SRCB_REGB : SRCB_IMM;
                    ALUcntrl = dec.alu;
                end
                ST_MEM: begin
                    IorD = 1'b1;
                    if (is_sw) begin
                        MemWr      = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                ST_WB: begin
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                    if (dec.rtype) begin
                        RegDst   = DST_RD;
                        MemToReg = WD_ALUOUT;
                    end else if (dec.mem) begin
                        RegDst   = DST_RT;
                        MemToReg = WD_MDR;
                    end else begin
                        RegDst   = DST_RT;
                        MemToReg = WD_ALUOUT;
                    end
                end
                ST_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_REGB;
                    ALUcntrl   = ALU_SUB;
                    PCSrc      = PCSRC_ALUOUT;
                    instr_done = 1'b1;
                    PCWr       = is_beq ? zero : ~zero;
                end
                ST_JUMP: begin
                    PCWr       = 1'b1;
                    instr_done = 1'b1;
                    PCSrc      = dec.jr ? PCSRC_REGA : PCSRC_JUMP;
                    if (dec.jal) begin
                        RegWr    = 1'b1;
                        RegDst   = DST_R31;
                        MemToReg = WD_PC;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle
// by cycle and compares the full control word against hand-built values.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       PCWr;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemWr;
    logic       IRWr;
    logic       RegWr;
    logic [1:0] RegDst;
    logic [1:0] MemToReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUcntrl;
    logic       instr_done;
    logic       halted;

    int checks;
    int failures;

    // Control word layout:
    // {PCWr, PCSrc, IorD, MemWr, IRWr, RegWr, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUcntrl, instr_done, halted}
    localparam logic [18:0] V_ZERO      = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_FETCH     = {1'b1,2'd0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,2'd1,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_DECODE    = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd3,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_EXEC_ADD  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_EXEC_SUB  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,3'd1,1'b0,1'b0};
    localparam logic [18:0] V_EXEC_SLT  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,3'd3,1'b0,1'b0};
    localparam logic [18:0] V_EXEC_IMM  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_EXEC_XORI = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,3'd2,1'b0,1'b0};
    localparam logic [18:0] V_MEM_LW    = {1'b0,2'd0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0};
    localparam logic [18:0] V_MEM_SW    = {1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_WB_R      = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_WB_IMM    = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_WB_LW     = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd1,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_BR_TAKEN  = {1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,3'd1,1'b1,1'b0};
    localparam logic [18:0] V_BR_NOT    = {1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,3'd1,1'b1,1'b0};
    localparam logic [18:0] V_JAL       = {1'b1,2'd2,1'b0,1'b0,1'b0,1'b1,2'd1,2'd2,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_J         = {1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_JR        = {1'b1,2'd3,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b1,1'b0};
    localparam logic [18:0] V_HALT      = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b1};

    logic [18:0] ctlWord;
    assign ctlWord = {PCWr, PCSrc, IorD, MemWr, IRWr, RegWr, RegDst, MemToReg,
                      ALUSrcA, ALUSrcB, ALUcntrl, instr_done, halted};

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .PCWr       (PCWr),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .MemWr      (MemWr),
        .IRWr       (IRWr),
        .RegWr      (RegWr),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUcntrl   (ALUcntrl),
        .instr_done (instr_done),
        .halted     (halted)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the control word is wrong
    task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    // Present an IR opcode/funct and zero flag to the controller
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    // Check the current cycle mid-period, then advance to just past the next edge
    task automatic stepCheck(input string tag, input logic [18:0] expected);
        @(negedge clk);
        checkOutput(tag, ctlWord, expected);
        @(posedge clk);
        #1;
    endtask

    // Directed instruction sequences
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(6'h00, 6'h00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        stepCheck("reset_outputs", V_ZERO);
        rst_n = 1'b1;

        // ADD: 4 cycles, done only in WB
        applyStimulus(6'h00, 6'h20, 1'b0);
        stepCheck("add_fetch", V_FETCH);
        stepCheck("add_decode", V_DECODE);
        stepCheck("add_exec", V_EXEC_ADD);
        stepCheck("add_wb", V_WB_R);

        // LW: 5 cycles, funct field must be ignored
        applyStimulus(6'h23, 6'h15, 1'b0);
        stepCheck("lw_fetch", V_FETCH);
        stepCheck("lw_decode", V_DECODE);
        stepCheck("lw_exec", V_EXEC_IMM);
        stepCheck("lw_mem", V_MEM_LW);
        stepCheck("lw_wb", V_WB_LW);

        // SW: finishes in MEM, never writes the register file
        applyStimulus(6'h2b, 6'h00, 1'b1);
        stepCheck("sw_fetch", V_FETCH);
        stepCheck("sw_decode", V_DECODE);
        stepCheck("sw_exec", V_EXEC_IMM);
        stepCheck("sw_mem", V_MEM_SW);

        // SUB with IR changed after DECODE: captured op must win
        applyStimulus(6'h00, 6'h22, 1'b0);
        stepCheck("sub_fetch", V_FETCH);
        stepCheck("sub_decode", V_DECODE);
        applyStimulus(6'h2b, 6'h00, 1'b1);
        stepCheck("sub_exec_ir_changed", V_EXEC_SUB);
        stepCheck("sub_wb", V_WB_R);

        // XORI
        applyStimulus(6'h0e, 6'h00, 1'b0);
        stepCheck("xori_fetch", V_FETCH);
        stepCheck("xori_decode", V_DECODE);
        stepCheck("xori_exec", V_EXEC_XORI);
        stepCheck("xori_wb", V_WB_IMM);

        // SLT
        applyStimulus(6'h00, 6'h2a, 1'b0);
        stepCheck("slt_fetch", V_FETCH);
        stepCheck("slt_decode", V_DECODE);
        stepCheck("slt_exec", V_EXEC_SLT);
        stepCheck("slt_wb", V_WB_R);

        // BEQ taken
        applyStimulus(6'h04, 6'h00, 1'b1);
        stepCheck("beq_fetch", V_FETCH);
        stepCheck("beq_decode", V_DECODE);
        stepCheck("beq_z1_branch", V_BR_TAKEN);

        // BNE with zero=1 is not taken
        applyStimulus(6'h05, 6'h00, 1'b1);
        stepCheck("bne_fetch", V_FETCH);
        stepCheck("bne_decode", V_DECODE);
        stepCheck("bne_z1_branch", V_BR_NOT);

        // BEQ with zero=0 is not taken
        applyStimulus(6'h04, 6'h00, 1'b0);
        stepCheck("beq0_fetch", V_FETCH);
        stepCheck("beq0_decode", V_DECODE);
        stepCheck("beq_z0_branch", V_BR_NOT);

        // BNE with zero=0 is taken
        applyStimulus(6'h05, 6'h00, 1'b0);
        stepCheck("bne0_fetch", V_FETCH);
        stepCheck("bne0_decode", V_DECODE);
        stepCheck("bne_z0_branch", V_BR_TAKEN);

        // JAL
        applyStimulus(6'h03, 6'h00, 1'b0);
        stepCheck("jal_fetch", V_FETCH);
        stepCheck("jal_decode", V_DECODE);
        stepCheck("jal_jump", V_JAL);

        // J
        applyStimulus(6'h02, 6'h08, 1'b0);
        stepCheck("j_fetch", V_FETCH);
        stepCheck("j_decode", V_DECODE);
        stepCheck("j_jump", V_J);

        // JR
        applyStimulus(6'h00, 6'h08, 1'b0);
        stepCheck("jr_fetch", V_FETCH);
        stepCheck("jr_decode", V_DECODE);
        stepCheck("jr_jump", V_JR);

        // ADDI aborted by reset during EXEC, then rerun to completion
        applyStimulus(6'h08, 6'h00, 1'b0);
        stepCheck("addi_fetch", V_FETCH);
        stepCheck("addi_decode", V_DECODE);
        rst_n = 1'b0;
        stepCheck("addi_exec_in_reset", V_ZERO);
        rst_n = 1'b1;
        stepCheck("addi_refetch_after_reset", V_FETCH);
        stepCheck("addi_decode2", V_DECODE);
        stepCheck("addi_exec", V_EXEC_IMM);
        stepCheck("addi_wb", V_WB_IMM);

        // Illegal opcode halts and stays halted
        applyStimulus(6'h3f, 6'h00, 1'b1);
        stepCheck("ill_fetch", V_FETCH);
        stepCheck("ill_decode", V_DECODE);
        applyStimulus(6'h00, 6'h20, 1'b0);
        for (int i = 0; i < 22; i++)
            stepCheck($sformatf("halt_hold_%0d", i), V_HALT);

        // Reset leaves HALT; illegal R-type funct also halts
        rst_n = 1'b0;
        stepCheck("halt_reset", V_ZERO);
        rst_n = 1'b1;
        applyStimulus(6'h00, 6'h3f, 1'b0);
        stepCheck("illfn_fetch", V_FETCH);
        stepCheck("illfn_decode", V_DECODE);
        stepCheck("illfn_halt", V_HALT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
